// File: rtl/fx_arb_if.sv
// Bundle of the two requesting masters' handshakes and the shared fx bus.
// The slave modport faces the arbiter; the master modport faces requesters and the fx bus model.
interface fx_arb_if;
  logic        m0_req;
  logic        m1_req;
  logic        m0_we;
  logic        m1_we;
  logic [15:0] m0_addr;
  logic [15:0] m1_addr;
  logic [7:0]  m0_wdata;
  logic [7:0]  m1_wdata;
  logic        m0_ack;
  logic        m1_ack;
  logic [7:0]  m0_rdata;
  logic [7:0]  m1_rdata;
  logic [15:0] fx_waddr;
  logic [7:0]  fx_data;
  logic        fx_wr;
  logic [15:0] fx_raddr;
  logic        fx_rd;
  logic [7:0]  fx_q;
  logic        busy;
  logic        owner;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, fx_q,
    output m0_ack, m1_ack, m0_rdata, m1_rdata, fx_waddr, fx_data, fx_wr, fx_raddr, fx_rd,
           busy, owner
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, fx_q,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata, fx_waddr, fx_data, fx_wr, fx_raddr, fx_rd,
           busy, owner
  );
endinterface

// File: rtl/fx_arb.sv
// Two-master round-robin arbiter onto the fx bus: one transaction at a time,
// single-cycle write strobe, read strobe followed by an RD_LAT-cycle wait for fx_q.
module fx_arb #(
  parameter int RD_LAT = 2
) (
  input  logic      clk_sys,
  input  logic      rst_n,
  fx_arb_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, ACK} state_e;

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        rr_q;
  logic        owner_q;
  logic        busy_q;
  logic        fx_wr_q;
  logic        fx_rd_q;
  logic [15:0] fx_waddr_q;
  logic [15:0] fx_raddr_q;
  logic [7:0]  fx_data_q;
  logic        ack0_q;
  logic        ack1_q;
  logic [7:0]  rdata0_q;
  logic [7:0]  rdata1_q;

  logic        req_any_d;
  logic        owner_d;
  logic        sel_we_d;
  logic [15:0] sel_addr_d;
  logic [7:0]  sel_wdata_d;

  // rr_q holds the last-served master; on a tie the other one wins.
  always_comb begin
    req_any_d = bus.m0_req | bus.m1_req;
    owner_d   = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      owner_d = ~rr_q;
    end else if (bus.m1_req) begin
      owner_d = 1'b1;
    end
    sel_we_d    = owner_d ? bus.m1_we    : bus.m0_we;
    sel_addr_d  = owner_d ? bus.m1_addr  : bus.m0_addr;
    sel_wdata_d = owner_d ? bus.m1_wdata : bus.m0_wdata;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      rr_q       <= 1'b1;
      owner_q    <= 1'b0;
      busy_q     <= 1'b0;
      fx_wr_q    <= 1'b0;
      fx_rd_q    <= 1'b0;
      fx_waddr_q <= 16'h0000;
      fx_raddr_q <= 16'h0000;
      fx_data_q  <= 8'h00;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= 8'h00;
      rdata1_q   <= 8'h00;
    end else begin
      fx_wr_q <= 1'b0;
      fx_rd_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Strobes are loaded on the grant edge so they line up with the WR/RD state.
          if (req_any_d) begin
            owner_q <= owner_d;
            busy_q  <= 1'b1;
            if (sel_we_d) begin
              state_q    <= WR;
              fx_wr_q    <= 1'b1;
              fx_waddr_q <= sel_addr_d;
              fx_data_q  <= sel_wdata_d;
            end else begin
              state_q    <= RD;
              fx_rd_q    <= 1'b1;
              fx_raddr_q <= sel_addr_d;
            end
          end
        end
        WR: begin
          state_q <= ACK;
          ack0_q  <= ~owner_q;
          ack1_q  <= owner_q;
        end
        RD: begin
          state_q <= WAIT;
          cnt_q   <= CNT_INIT;
        end
        WAIT: begin
          // cnt_q reaches zero exactly RD_LAT cycles after the fx_rd cycle.
          if (cnt_q == 3'd0) begin
            state_q <= ACK;
            ack0_q  <= ~owner_q;
            ack1_q  <= owner_q;
            if (owner_q) begin
              rdata1_q <= bus.fx_q;
            end else begin
              rdata0_q <= bus.fx_q;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rr_q    <= owner_q;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m0_ack   = ack0_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;
  assign bus.fx_waddr = fx_waddr_q;
  assign bus.fx_data  = fx_data_q;
  assign bus.fx_wr    = fx_wr_q;
  assign bus.fx_raddr = fx_raddr_q;
  assign bus.fx_rd    = fx_rd_q;
  assign bus.busy     = busy_q;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_fx_arb.sv
// Directed bench for fx_arb: two instances (RD_LAT=2 and RD_LAT=7) sharing clock and reset.
module tb_fx_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   overlap = 0;

  always #5 clk = ~clk;

  fx_arb_if bus();
  fx_arb_if bus7();

  fx_arb #(.RD_LAT(2)) dut  (.clk_sys(clk), .rst_n(rst_n), .bus(bus));
  fx_arb #(.RD_LAT(7)) dut7 (.clk_sys(clk), .rst_n(rst_n), .bus(bus7));

  always @(negedge clk) begin
    if ((bus.fx_wr && bus.fx_rd) || (bus7.fx_wr && bus7.fx_rd)) overlap <= overlap + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    bus.m0_req = 0; bus.m1_req = 0; bus.m0_we = 0; bus.m1_we = 0;
    bus.m0_addr = 0; bus.m1_addr = 0; bus.m0_wdata = 0; bus.m1_wdata = 0; bus.fx_q = 0;
    bus7.m0_req = 0; bus7.m1_req = 0; bus7.m0_we = 0; bus7.m1_we = 0;
    bus7.m0_addr = 0; bus7.m1_addr = 0; bus7.m0_wdata = 0; bus7.m1_wdata = 0; bus7.fx_q = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.m0_ack, bus.m1_ack, bus.fx_wr, bus.fx_rd, bus.busy, bus.owner} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {bus.m0_ack, bus.m1_ack, bus.fx_wr, bus.fx_rd, bus.busy, bus.owner});
    end
    checks++;
    if ({bus.fx_waddr, bus.fx_raddr, bus.fx_data, bus.m0_rdata, bus.m1_rdata} !== 56'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0",
               {bus.fx_waddr, bus.fx_raddr, bus.fx_data, bus.m0_rdata, bus.m1_rdata});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    logic rd_seen;
    rd_seen = 1'b0;
    bus.m0_we = 1; bus.m0_addr = 16'h1105; bus.m0_wdata = 8'hA5; bus.m0_req = 1;
    @(negedge clk);
    rd_seen |= bus.fx_rd;
    checks++;
    if ({bus.busy, bus.fx_wr} !== 2'b00) begin
      errors++; $display("FAIL wr_t0 busy/fx_wr got %b want 00", {bus.busy, bus.fx_wr});
    end
    @(negedge clk);
    rd_seen |= bus.fx_rd;
    checks++;
    if ({bus.fx_wr, bus.busy, bus.owner, bus.m0_ack} !== 4'b1100) begin
      errors++; $display("FAIL wr_t1 wr/busy/owner/ack got %b want 1100",
                         {bus.fx_wr, bus.busy, bus.owner, bus.m0_ack});
    end
    checks++;
    if ({bus.fx_waddr, bus.fx_data} !== 24'h1105A5) begin
      errors++; $display("FAIL wr_bus got %h want 1105a5", {bus.fx_waddr, bus.fx_data});
    end
    @(negedge clk);
    rd_seen |= bus.fx_rd;
    checks++;
    if ({bus.m0_ack, bus.m1_ack, bus.fx_wr} !== 3'b100) begin
      errors++; $display("FAIL wr_ack got %b want 100", {bus.m0_ack, bus.m1_ack, bus.fx_wr});
    end
    step();
    bus.m0_req = 0;
    @(negedge clk);
    rd_seen |= bus.fx_rd;
    checks++;
    if ({bus.m0_ack, bus.busy} !== 2'b00 || {bus.fx_waddr, bus.fx_data} !== 24'h1105A5) begin
      errors++; $display("FAIL wr_hold got ack/busy %b bus %h want 00 1105a5",
                         {bus.m0_ack, bus.busy}, {bus.fx_waddr, bus.fx_data});
    end
    checks++;
    if (rd_seen !== 1'b0) begin
      errors++; $display("FAIL wr_no_rd got %b want 0", rd_seen);
    end
    step();
  endtask

  task automatic test_read();
    int lat;
    bus.fx_q = 8'hEE; bus.m1_we = 0; bus.m1_addr = 16'h2001; bus.m1_req = 1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.fx_rd, bus.fx_wr, bus.owner} !== 3'b101 || bus.fx_raddr !== 16'h2001) begin
      errors++; $display("FAIL rd_strobe got rd/wr/owner %b raddr %h want 101 2001",
                         {bus.fx_rd, bus.fx_wr, bus.owner}, bus.fx_raddr);
    end
    step();
    @(negedge clk);
    checks++;
    if ({bus.fx_rd, bus.m1_ack} !== 2'b00) begin
      errors++; $display("FAIL rd_t2 got %b want 00", {bus.fx_rd, bus.m1_ack});
    end
    step();
    bus.fx_q = 8'h3C;
    @(negedge clk);
    checks++;
    if (bus.m1_ack !== 1'b0) begin
      errors++; $display("FAIL rd_t3_ack got %b want 0", bus.m1_ack);
    end
    step();
    bus.fx_q = 8'hEE;
    @(negedge clk);
    checks++;
    if ({bus.m1_ack, bus.m0_ack} !== 2'b10 || bus.m1_rdata !== 8'h3C || bus.m0_rdata !== 8'h00) begin
      errors++; $display("FAIL rd_ack got ack %b m1_rdata %h m0_rdata %h want 10 3c 00",
                         {bus.m1_ack, bus.m0_ack}, bus.m1_rdata, bus.m0_rdata);
    end
    step();
    bus.m1_req = 0;
    @(negedge clk);
    checks++;
    if (bus.m1_ack !== 1'b0 || bus.m1_rdata !== 8'h3C) begin
      errors++; $display("FAIL rd_after got ack %b rdata %h want 0 3c", bus.m1_ack, bus.m1_rdata);
    end
    step();
    bus.fx_q = 8'h5A; bus.m0_we = 0; bus.m0_addr = 16'h0042; bus.m0_req = 1;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.m0_ack) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 4 || bus.m0_rdata !== 8'h5A || bus.m1_rdata !== 8'h3C) begin
      errors++; $display("FAIL rd_m0 got lat %0d m0_rdata %h m1_rdata %h want 4 5a 3c",
                         lat, bus.m0_rdata, bus.m1_rdata);
    end
    step();
    bus.m0_req = 0;
    step();
  endtask

  task automatic test_drop();
    int a;
    int w;
    a = 0; w = 0;
    bus.m0_we = 1; bus.m0_addr = 16'h4444; bus.m0_wdata = 8'h11; bus.m0_req = 1;
    step();
    bus.m0_req = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      a += int'(bus.m0_ack);
      w += int'(bus.fx_wr);
    end
    checks++;
    if (a !== 1 || w !== 1) begin
      errors++; $display("FAIL drop_count got acks %0d wrs %0d want 1 1", a, w);
    end
    checks++;
    if (bus.m0_rdata !== 8'h5A || bus.fx_waddr !== 16'h4444) begin
      errors++; $display("FAIL drop_data got rdata %h waddr %h want 5a 4444",
                         bus.m0_rdata, bus.fx_waddr);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic        wr_l[7];
    logic [15:0] ad_l[7];
    logic        a0_l[7];
    logic        a1_l[7];
    logic        bz_l[7];
    bus.m1_we = 1; bus.m1_addr = 16'hB2B2; bus.m1_wdata = 8'h22; bus.m1_req = 1;
    bus.m0_we = 1; bus.m0_addr = 16'hA1A1; bus.m0_wdata = 8'h33;
    step();
    bus.m0_req = 1;
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      wr_l[k] = bus.fx_wr; ad_l[k] = bus.fx_waddr;
      a0_l[k] = bus.m0_ack; a1_l[k] = bus.m1_ack; bz_l[k] = bus.busy;
      step();
      if (a1_l[k]) bus.m1_req = 0;
      if (a0_l[k]) bus.m0_req = 0;
    end
    checks++;
    if (wr_l[1] !== 1'b1 || ad_l[1] !== 16'hB2B2 || a1_l[2] !== 1'b1 || a0_l[2] !== 1'b0) begin
      errors++; $display("FAIL b2b_m1 got wr %b addr %h ack1 %b ack0 %b want 1 b2b2 1 0",
                         wr_l[1], ad_l[1], a1_l[2], a0_l[2]);
    end
    checks++;
    if (bz_l[3] !== 1'b0 || wr_l[3] !== 1'b0 || a0_l[3] !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got busy %b wr %b ack0 %b want 0 0 0",
                         bz_l[3], wr_l[3], a0_l[3]);
    end
    checks++;
    if (wr_l[4] !== 1'b1 || ad_l[4] !== 16'hA1A1 || a0_l[5] !== 1'b1 || a1_l[5] !== 1'b0) begin
      errors++; $display("FAIL b2b_m0 got wr %b addr %h ack0 %b ack1 %b want 1 a1a1 1 0",
                         wr_l[4], ad_l[4], a0_l[5], a1_l[5]);
    end
    checks++;
    if (wr_l[6] !== 1'b0 || a0_l[6] !== 1'b0 || bus.m1_rdata !== 8'h3C) begin
      errors++; $display("FAIL b2b_tail got wr %b ack0 %b m1_rdata %h want 0 0 3c",
                         wr_l[6], a0_l[6], bus.m1_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] order[8];
    logic [15:0] exp_addr;
    int n0, n1, ng, both;
    n0 = 0; n1 = 0; ng = 0; both = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    checks++;
    if (bus.m0_rdata !== 8'h00 || bus.m1_rdata !== 8'h00) begin
      errors++; $display("FAIL rr_reset_rdata got %h %h want 00 00", bus.m0_rdata, bus.m1_rdata);
    end
    bus.m0_we = 1; bus.m0_addr = 16'h0A00; bus.m1_we = 1; bus.m1_addr = 16'h0B00;
    bus.m0_req = 1; bus.m1_req = 1;
    for (int c = 0; c < 60 && (n0 < 3 || n1 < 3); c++) begin
      @(negedge clk);
      if (bus.fx_wr) begin
        if (ng < 8) order[ng] = bus.fx_waddr;
        ng++;
      end
      if (bus.m0_ack && bus.m1_ack) both++;
      if (bus.m0_ack) n0++;
      if (bus.m1_ack) n1++;
      step();
      if (n0 >= 3) bus.m0_req = 0;
      if (n1 >= 3) bus.m1_req = 0;
    end
    checks++;
    if (ng !== 6 || n0 !== 3 || n1 !== 3 || both !== 0) begin
      errors++; $display("FAIL rr_counts got grants %0d ack0 %0d ack1 %0d both %0d want 6 3 3 0",
                         ng, n0, n1, both);
    end
    for (int i = 0; i < 6 && i < ng; i++) begin
      exp_addr = (i % 2 == 0) ? 16'h0A00 : 16'h0B00;
      checks++;
      if (order[i] !== exp_addr) begin
        errors++; $display("FAIL rr_order[%0d] got %h want %h", i, order[i], exp_addr);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL rr_idle busy got %b want 0", bus.busy);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int early;
    int n;
    int lat;
    early = 0; n = 0; lat = -1;
    bus7.m1_we = 0; bus7.m1_addr = 16'h3333; bus7.fx_q = 8'h77; bus7.m1_req = 1;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      early += int'(bus7.m1_ack);
    end
    checks++;
    if ({bus7.busy, bus7.owner} !== 2'b11 || early !== 0) begin
      errors++; $display("FAIL mid_pre got busy/owner %b early acks %0d want 11 0",
                         {bus7.busy, bus7.owner}, early);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({bus7.busy, bus7.owner, bus7.m0_ack, bus7.m1_ack, bus7.fx_wr, bus7.fx_rd} !== 6'b0 ||
        bus7.fx_raddr !== 16'h0000 || bus7.m1_rdata !== 8'h00) begin
      errors++; $display("FAIL mid_async got ctrl %b raddr %h rdata %h want 000000 0000 00",
                         {bus7.busy, bus7.owner, bus7.m0_ack, bus7.m1_ack, bus7.fx_wr, bus7.fx_rd},
                         bus7.fx_raddr, bus7.m1_rdata);
    end
    step();
    checks++;
    if ({bus7.busy, bus7.m1_ack, bus7.fx_rd} !== 3'b000) begin
      errors++; $display("FAIL mid_held got %b want 000", {bus7.busy, bus7.m1_ack, bus7.fx_rd});
    end
    rst_n = 1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus7.m1_ack) begin
        if (n == 0) lat = k;
        n++;
      end
      step();
      if (n > 0) bus7.m1_req = 0;
    end
    checks++;
    if (n !== 1 || lat !== 9 || bus7.m1_rdata !== 8'h77) begin
      errors++; $display("FAIL mid_reserve got acks %0d lat %0d rdata %h want 1 9 77",
                         n, lat, bus7.m1_rdata);
    end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_write();
    test_read();
    test_drop();
    test_back_to_back();
    test_round_robin();
    test_reset_mid();
    checks++;
    if (overlap !== 0) begin
      errors++; $display("FAIL no_overlap got %0d want 0", overlap);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
